// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop walk
// the operands LSB first, committing s/c/v once every bit has been processed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic [WIDTH-2:0] res_q;
  logic             carry_q, cmsb_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q, v_q, busy_q, done_q;

  logic             sumBit, carry_d;
  logic [WIDTH-1:0] res_d;

  // res_d is the partial result with the current bit shifted in; on the last
  // bit it is the complete sum, so it feeds both the shift and the commit.
  assign sumBit  = opA_q[0] ^ opB_q[0] ^ carry_q;
  assign carry_d = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);
  assign res_d   = {sumBit, res_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Subtraction is a + ~b + 1; a borrow-in cancels that +1.
          if (start) begin
            opA_q   <= a;
            opB_q   <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opA_q   <= opA_q >> 1;
          opB_q   <= opB_q >> 1;
          res_q   <= res_d[WIDTH-1:1];
          carry_q <= carry_d;
          if (cnt_q == PENULT) cmsb_q <= carry_d;
          // Overflow is the carry into the sign bit disagreeing with the carry out of it.
          if (cnt_q == LAST) begin
            s_q     <= res_d;
            c_q     <= carry_d;
            v_q     <= cmsb_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;
  assign v    = v_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, 2 and 32, checking results,
// latency, handshake filtering and asynchronous abort.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, cin8, sub8, busy8, done8, c8, v8;
  logic [7:0] a8, b8, s8;
  logic       start2, cin2, sub2, busy2, done2, c2, v2;
  logic [1:0] a2, b2, s2;
  logic        start32, cin32, sub32, busy32, done32, c32, v32;
  logic [31:0] a32, b32, s32;

  int assertions = 0;
  int failures   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .c(c8), .v(v8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .s(s2), .c(c2), .v(v2)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .busy(busy32), .done(done32), .s(s32), .c(c32), .v(v32)
  );

  // Single comparison point: counts every evaluation and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents an 8-bit request for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic opCin, input logic opSub);
    @(negedge clk);
    a8 = opA; b8 = opB; cin8 = opCin; sub8 = opSub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts busy cycles until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic waitDone8(output int busyCount);
    busyCount = 0;
    for (int i = 0; i < 40 && !done8; i++) begin
      if (busy8) busyCount++;
      @(negedge clk);
    end
  endtask

  task automatic runCheck8(input string tag, input logic [7:0] opA, input logic [7:0] opB,
                           input logic opCin, input logic opSub,
                           input logic [7:0] expS, input logic expC, input logic expV);
    int n;
    applyStimulus(opA, opB, opCin, opSub);
    waitDone8(n);
    checkOutput({tag, "_done"}, done8, 1);
    checkOutput({tag, "_lat"}, n, 8);
    checkOutput({tag, "_s"}, s8, expS);
    checkOutput({tag, "_c"}, c8, expC);
    checkOutput({tag, "_v"}, v8, expV);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, done8, 0);
  endtask

  task automatic runCheck2(input string tag, input logic [1:0] opA, input logic [1:0] opB,
                           input logic opCin, input logic opSub,
                           input logic [1:0] expS, input logic expC, input logic expV);
    int n = 0;
    @(negedge clk);
    a2 = opA; b2 = opB; cin2 = opCin; sub2 = opSub; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20 && !done2; i++) begin
      if (busy2) n++;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, done2, 1);
    checkOutput({tag, "_lat"}, n, 2);
    checkOutput({tag, "_s"}, s2, expS);
    checkOutput({tag, "_c"}, c2, expC);
    checkOutput({tag, "_v"}, v2, expV);
  endtask

  task automatic runCheck32(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                            input logic opCin, input logic opSub,
                            input logic [31:0] expS, input logic expC, input logic expV,
                            input logic checkLat);
    int n = 0;
    @(negedge clk);
    a32 = opA; b32 = opB; cin32 = opCin; sub32 = opSub; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 110 && !done32; i++) begin
      if (busy32) n++;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, done32, 1);
    if (checkLat) checkOutput({tag, "_lat"}, n, 32);
    checkOutput({tag, "_s"}, s32, expS);
    checkOutput({tag, "_c"}, c32, expC);
    checkOutput({tag, "_v"}, v32, expV);
  endtask

  initial begin
    int n, seen;
    logic [31:0] ra, rb, es;
    logic        rcin, rsub, ec, ev;
    logic [32:0] wide;

    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    start2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0;
    start32 = 0; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0;

    #2;
    checkOutput("rst_s", s8, 8'h00);
    checkOutput("rst_c", c8, 0);
    checkOutput("rst_v", v8, 0);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("idle_s", s8, 8'h00);
    checkOutput("idle_busy", busy8, 0);
    checkOutput("idle_done", done8, 0);

    $display("[TB] add/sub vectors, WIDTH=8");
    runCheck8("add1", 8'h5A, 8'h33, 0, 0, 8'h8D, 0, 1);
    runCheck8("add2", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    runCheck8("sub1", 8'h10, 8'h01, 0, 1, 8'h0F, 1, 0);
    runCheck8("sub2", 8'h00, 8'h01, 0, 1, 8'hFF, 0, 0);
    runCheck8("sub3", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    runCheck8("sub4", 8'h05, 8'h02, 1, 1, 8'h02, 1, 0);

    $display("[TB] start ignored during RUN and DONE");
    applyStimulus(8'h5A, 8'h33, 0, 0);
    repeat (2) @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(n);
    checkOutput("hs_done", done8, 1);
    checkOutput("hs_lat", n, 5);
    checkOutput("hs_s", s8, 8'h8D);
    checkOutput("hs_c", c8, 0);
    checkOutput("hs_v", v8, 1);
    a8 = 8'h22; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("hs_done_busy", busy8, 0);
    checkOutput("hs_done_pulse", done8, 0);
    @(negedge clk);
    checkOutput("hs_idle_busy", busy8, 0);
    checkOutput("hs_idle_s", s8, 8'h8D);

    $display("[TB] back-to-back with start held high");
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; cin8 = 0; sub8 = 1; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; cin8 = 1; sub8 = 0;
    waitDone8(n);
    checkOutput("b2b1_lat", n, 8);
    checkOutput("b2b1_s", s8, 8'h0F);
    checkOutput("b2b1_c", c8, 1);
    @(negedge clk);
    checkOutput("b2b_gap_busy", busy8, 0);
    checkOutput("b2b_gap_done", done8, 0);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("b2b_accept_busy", busy8, 1);
    checkOutput("b2b_hold_s", s8, 8'h0F);
    waitDone8(n);
    checkOutput("b2b2_lat", n, 8);
    checkOutput("b2b2_s", s8, 8'h08);
    checkOutput("b2b2_c", c8, 0);
    checkOutput("b2b2_v", v8, 0);

    $display("[TB] asynchronous abort");
    applyStimulus(8'hFF, 8'hFF, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_s", s8, 8'h00);
    checkOutput("abort_c", c8, 0);
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    checkOutput("abort_nodone", seen, 0);
    runCheck8("post_abort", 8'hFF, 8'hFF, 0, 0, 8'hFE, 1, 0);

    $display("[TB] WIDTH=2");
    runCheck2("w2_add", 2'd3, 2'd1, 0, 0, 2'd0, 1, 0);
    runCheck2("w2_sub", 2'd1, 2'd2, 0, 1, 2'd3, 0, 1);

    $display("[TB] WIDTH=32");
    runCheck32("w32_ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 1);
    runCheck32("w32_brw", 32'h0, 32'h1, 0, 1, 32'hFFFF_FFFF, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      if (!rsub) begin
        wide = {1'b0, ra} + {1'b0, rb} + 33'(rcin);
        es = wide[31:0];
        ec = wide[32];
        ev = (ra[31] == rb[31]) && (es[31] != ra[31]);
      end else begin
        es = ra - rb - 32'(rcin);
        ec = ({1'b0, ra} >= ({1'b0, rb} + 33'(rcin)));
        ev = (ra[31] != rb[31]) && (es[31] != ra[31]);
      end
      runCheck32("w32_rand", ra, rb, rcin, rsub, es, ec, ev, (i % 100) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
